adc_ser: RTL

- Four-lane, MSB-first serial transmitter that emulates the ADC output stream, for the pattern generator.
- Feeds the ADC deserializer on the receiving side: drives lanes A–D plus a frame clock, all from one bit clock.
- Each frame carries one WIDTH-bit word per lane. The word comes from a parallel valid/ready input or from a built-in test pattern.

---
 rtl/adc_ser.sv | 110 +++++++++++
 1 files changed

// File: rtl/adc_ser.sv
// Four-lane MSB-first serial transmitter that emulates an ADC output stream.
// Each frame carries one WIDTH-bit word per lane, with a frame clock aligned to the word MSB.
module adc_ser #(
   parameter int               WIDTH     = 12,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             d_clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dat_A,
   input  logic [WIDTH-1:0] in_dat_B,
   input  logic [WIDTH-1:0] in_dat_C,
   input  logic [WIDTH-1:0] in_dat_D,
   output logic             ser_dat_A,
   output logic             ser_dat_B,
   output logic             ser_dat_C,
   output logic             ser_dat_D,
   output logic             fclk,
   output logic [CNT_W-1:0] underrun_cnt
);

   localparam int               BW         = $clog2(WIDTH);
   localparam logic [BW-1:0]    LAST_BIT   = BW'(WIDTH - 1);
   localparam logic [BW-1:0]    HALF       = BW'(WIDTH / 2);
   localparam logic [WIDTH-1:0] TOGGLE_PAT = {(WIDTH/2){2'b10}};

   typedef enum logic [1:0] {
      MODE_DATA   = 2'd0,
      MODE_IDLE   = 2'd1,
      MODE_RAMP   = 2'd2,
      MODE_TOGGLE = 2'd3
   } mode_e;

   mode_e            src;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    next_cnt;
   logic             load;
   logic [WIDTH-1:0] shift_a, shift_b, shift_c, shift_d;
   logic [WIDTH-1:0] ramp;
   logic             phase;
   logic             use_inputs;
   logic             count_underrun;
   logic [WIDTH-1:0] pattern;

   assign src      = mode_e'(mode);
   assign load     = (bit_cnt == LAST_BIT);
   assign next_cnt = load ? '0 : bit_cnt + BW'(1);
   assign in_ready = load && (src == MODE_DATA);

   assign ser_dat_A = shift_a[WIDTH-1];
   assign ser_dat_B = shift_b[WIDTH-1];
   assign ser_dat_C = shift_c[WIDTH-1];
   assign ser_dat_D = shift_d[WIDTH-1];

   // Word source for the next frame; only meaningful on a load cycle.
   always_comb begin
      use_inputs     = 1'b0;
      count_underrun = 1'b0;
      pattern        = IDLE_WORD;
      case (src)
         MODE_DATA: begin
            if (in_valid) use_inputs     = 1'b1;
            else          count_underrun = 1'b1;
         end
         MODE_IDLE:   pattern = IDLE_WORD;
         MODE_RAMP:   pattern = ramp;
         MODE_TOGGLE: pattern = phase ? ~TOGGLE_PAT : TOGGLE_PAT;
         default:     pattern = IDLE_WORD;
      endcase
   end

   always_ff @(posedge d_clk or posedge reset) begin
      if (reset) begin
         bit_cnt      <= LAST_BIT;
         shift_a      <= '0;
         shift_b      <= '0;
         shift_c      <= '0;
         shift_d      <= '0;
         fclk         <= 1'b0;
         underrun_cnt <= '0;
         ramp         <= '0;
         phase        <= 1'b0;
      end else begin
         bit_cnt <= next_cnt;
         // Registered from the next count so the rising edge lands with the MSB.
         fclk    <= (next_cnt < HALF);
         if (load) begin
            shift_a <= use_inputs ? in_dat_A : pattern;
            shift_b <= use_inputs ? in_dat_B : pattern;
            shift_c <= use_inputs ? in_dat_C : pattern;
            shift_d <= use_inputs ? in_dat_D : pattern;
            if (count_underrun && (underrun_cnt != '1))
               underrun_cnt <= underrun_cnt + CNT_W'(1);
            if (src == MODE_RAMP)
               ramp <= ramp + WIDTH'(1);
            if (src == MODE_TOGGLE)
               phase <= ~phase;
         end else begin
            shift_a <= {shift_a[WIDTH-2:0], 1'b0};
            shift_b <= {shift_b[WIDTH-2:0], 1'b0};
            shift_c <= {shift_c[WIDTH-2:0], 1'b0};
            shift_d <= {shift_d[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule
